ibex_rf_wb_arbiter: RTL and testbench

IBEX_RF_WB_ARBITER -- requirements
Module: ibex_rf_wb_arbiter

---
 rtl/ibex_rf_wb_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_ibex_rf_wb_arbiter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ibex_rf_wb_arbiter.sv
// Register-file writeback arbiter.
// Merges single-cycle EX results and load responses onto one register-file
// write port. EX results that lose arbitration wait in a small in-order
// buffer. A pending bitmap tracks the destination of the outstanding load so
// that the ID stage can be stalled on RAW/WAW hazards.
module ibex_rf_wb_arbiter #(
    parameter int unsigned DataWidth   = 32,
    parameter int unsigned WbFifoDepth = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,

    input  logic                 ex_we_i,
    input  logic [4:0]           ex_waddr_i,
    input  logic [DataWidth-1:0] ex_wdata_i,

    input  logic                 lsu_issue_i,
    input  logic [4:0]           lsu_rd_i,
    input  logic                 lsu_resp_valid_i,
    input  logic                 lsu_resp_err_i,
    input  logic [DataWidth-1:0] lsu_rdata_i,

    input  logic                 id_valid_i,
    input  logic [4:0]           id_raddr_a_i,
    input  logic                 id_ra_used_i,
    input  logic [4:0]           id_raddr_b_i,
    input  logic                 id_rb_used_i,
    input  logic [4:0]           id_waddr_i,
    input  logic                 id_we_i,

    output logic [4:0]           waddr_a_o,
    output logic [DataWidth-1:0] wdata_a_o,
    output logic                 we_a_o,
    output logic                 reg_stall_o,
    output logic                 lsu_busy_o
);

    localparam int unsigned PtrW = (WbFifoDepth > 1) ? $clog2(WbFifoDepth) : 1;
    localparam int unsigned CntW = $clog2(WbFifoDepth + 1);

    typedef struct packed {
        logic [4:0]           waddr;
        logic [DataWidth-1:0] wdata;
    } wb_entry_t;

    // Load tracking state.
    logic [31:0]            pending_q;
    logic [31:0]            pending_d;
    logic                   rec_valid_q;
    logic [4:0]             rec_rd_q;

    // EX writeback buffer: circular, with a valid bit per slot for the
    // hazard lookup.
    wb_entry_t              fifo_q [WbFifoDepth];
    logic [WbFifoDepth-1:0] fifo_vld_q;
    logic [PtrW-1:0]        rd_ptr_q;
    logic [PtrW-1:0]        wr_ptr_q;
    logic [CntW-1:0]        count_q;

    logic                   fifo_empty;
    logic                   fifo_full;
    logic                   lsu_done;
    logic                   lsu_wr;
    logic                   lsu_accept;
    logic                   ex_valid;
    logic                   ex_direct;
    logic                   fifo_pop;
    logic                   fifo_push;
    logic                   fifo_hit_a;
    logic                   fifo_hit_b;
    logic                   hit_a;
    logic                   hit_b;
    logic                   raw;
    logic                   waw;
    logic                   backpressure;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CntW'(WbFifoDepth));

    // A response only counts when a load is actually outstanding; a
    // response after reset or with no load in flight is ignored.
    assign lsu_done   = lsu_resp_valid_i & rec_valid_q;
    assign lsu_wr     = lsu_done & ~lsu_resp_err_i & (rec_rd_q != 5'd0);
    assign lsu_accept = lsu_issue_i & (~rec_valid_q | lsu_done);

    // EX writes to x0 are discarded entirely. Gating with rst_ni keeps the
    // write port quiet while reset is held.
    assign ex_valid   = rst_ni & ex_we_i & (ex_waddr_i != 5'd0);
    assign ex_direct  = ex_valid & ~lsu_wr & fifo_empty;
    assign fifo_pop   = ~fifo_empty & ~lsu_wr;
    // A push into a full buffer is dropped unless the head leaves this cycle.
    assign fifo_push  = ex_valid & ~ex_direct & (~fifo_full | fifo_pop);

    // Write-port mux: load response, then buffered EX, then direct EX.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // that no path through the if/else chain leaves it unassigned (latch).
        we_a_o    = 1'b0;
        waddr_a_o = 5'd0;
        wdata_a_o = '0;
        if (lsu_wr) begin
            we_a_o    = 1'b1;
            waddr_a_o = rec_rd_q;
            wdata_a_o = lsu_rdata_i;
        end else if (fifo_pop) begin
            we_a_o    = 1'b1;
            waddr_a_o = fifo_q[rd_ptr_q].waddr;
            wdata_a_o = fifo_q[rd_ptr_q].wdata;
        end else if (ex_direct) begin
            we_a_o    = 1'b1;
            waddr_a_o = ex_waddr_i;
            wdata_a_o = ex_wdata_i;
        end
    end

    // Look up both ID read operands in the buffered EX writes.
    always_comb begin
        fifo_hit_a = 1'b0;
        fifo_hit_b = 1'b0;
        for (int i = 0; i < WbFifoDepth; i++) begin
            if (fifo_vld_q[i] && (fifo_q[i].waddr == id_raddr_a_i)) fifo_hit_a = 1'b1;
            if (fifo_vld_q[i] && (fifo_q[i].waddr == id_raddr_b_i)) fifo_hit_b = 1'b1;
        end
    end

    assign hit_a        = (id_raddr_a_i != 5'd0) & (pending_q[id_raddr_a_i] | fifo_hit_a);
    assign hit_b        = (id_raddr_b_i != 5'd0) & (pending_q[id_raddr_b_i] | fifo_hit_b);
    assign raw          = (id_ra_used_i & hit_a) | (id_rb_used_i & hit_b);
    assign waw          = id_we_i & pending_q[id_waddr_i];
    // Stall one entry early so the EX write already in flight still fits.
    assign backpressure = (count_q >= CntW'(WbFifoDepth - 1));
    assign reg_stall_o  = (id_valid_i & (raw | waw)) | backpressure;
    assign lsu_busy_o   = rec_valid_q;

    // Next pending bitmap: retire the completing load, then mark the new one,
    // so a retire and re-issue to the same register leaves the bit set.
    always_comb begin
        pending_d = pending_q;
        if (lsu_done) pending_d[rec_rd_q] = 1'b0;
        if (lsu_accept) pending_d[lsu_rd_i] = 1'b1;
        pending_d[0] = 1'b0;
    end

    // Outstanding-load record and pending bitmap.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values, independent of statement order.
        if (!rst_ni) begin
            pending_q   <= '0;
            rec_valid_q <= 1'b0;
            rec_rd_q    <= 5'd0;
        end else begin
            pending_q <= pending_d;
            if (lsu_accept) begin
                rec_valid_q <= 1'b1;
                rec_rd_q    <= lsu_rd_i;
            end else if (lsu_done) begin
                rec_valid_q <= 1'b0;
            end
        end
    end

    // Buffer control: pointers, occupancy and per-slot valid bits.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            fifo_vld_q <= '0;
        end else begin
            if (fifo_pop) begin
                fifo_vld_q[rd_ptr_q] <= 1'b0;
                rd_ptr_q <= (rd_ptr_q == PtrW'(WbFifoDepth - 1)) ? '0 : rd_ptr_q + PtrW'(1);
            end
            // Placed after the pop so a same-slot push/pop leaves the slot valid.
            if (fifo_push) begin
                fifo_vld_q[wr_ptr_q] <= 1'b1;
                wr_ptr_q <= (wr_ptr_q == PtrW'(WbFifoDepth - 1)) ? '0 : wr_ptr_q + PtrW'(1);
            end
            case ({fifo_push, fifo_pop})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Buffer payload storage.
    always_ff @(posedge clk_i) begin
        // NOTE: the payload array has no reset; the valid bits and counter
        // decide what is live, so stale contents are never observed.
        if (fifo_push) fifo_q[wr_ptr_q] <= '{waddr: ex_waddr_i, wdata: ex_wdata_i};
    end

endmodule

// File: tb/tb_ibex_rf_wb_arbiter.sv
// Testbench for ibex_rf_wb_arbiter: directed scenarios followed by random
// traffic, all checked every cycle against a transaction-level model.
module tb_ibex_rf_wb_arbiter;

    localparam int DW    = 32;
    localparam int DEPTH = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ex_we;
    logic [4:0]    ex_waddr;
    logic [DW-1:0] ex_wdata;
    logic          lsu_issue;
    logic [4:0]    lsu_rd;
    logic          lsu_resp_valid;
    logic          lsu_resp_err;
    logic [DW-1:0] lsu_rdata;
    logic          id_valid;
    logic [4:0]    id_raddr_a;
    logic          id_ra_used;
    logic [4:0]    id_raddr_b;
    logic          id_rb_used;
    logic [4:0]    id_waddr;
    logic          id_we;
    logic [4:0]    waddr_a;
    logic [DW-1:0] wdata_a;
    logic          we_a;
    logic          reg_stall;
    logic          lsu_busy;

    ibex_rf_wb_arbiter #(.DataWidth(DW), .WbFifoDepth(DEPTH)) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .ex_we_i          (ex_we),
        .ex_waddr_i       (ex_waddr),
        .ex_wdata_i       (ex_wdata),
        .lsu_issue_i      (lsu_issue),
        .lsu_rd_i         (lsu_rd),
        .lsu_resp_valid_i (lsu_resp_valid),
        .lsu_resp_err_i   (lsu_resp_err),
        .lsu_rdata_i      (lsu_rdata),
        .id_valid_i       (id_valid),
        .id_raddr_a_i     (id_raddr_a),
        .id_ra_used_i     (id_ra_used),
        .id_raddr_b_i     (id_raddr_b),
        .id_rb_used_i     (id_rb_used),
        .id_waddr_i       (id_waddr),
        .id_we_i          (id_we),
        .waddr_a_o        (waddr_a),
        .wdata_a_o        (wdata_a),
        .we_a_o           (we_a),
        .reg_stall_o      (reg_stall),
        .lsu_busy_o       (lsu_busy)
    );

    always #5 clk = ~clk;

    // Reference model: one outstanding load (the pending set is exactly its
    // destination) and a queue of EX writes waiting for the port.
    typedef struct {
        logic [4:0]    a;
        logic [DW-1:0] d;
    } ent_t;

    bit         m_busy;
    logic [4:0] m_rd;
    ent_t       m_q[$];

    int total = 0;
    int bad   = 0;

    // Values sampled by the most recent tick, for scenario-specific checks.
    logic          s_we;
    logic [4:0]    s_addr;
    logic [DW-1:0] s_data;
    logic          s_stall;
    logic          s_busy;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit hit(input logic [4:0] r);
        if (r == 5'd0) return 1'b0;
        if (m_busy && m_rd == r) return 1'b1;
        foreach (m_q[i]) if (m_q[i].a == r) return 1'b1;
        return 1'b0;
    endfunction

    task automatic idle_inputs();
        ex_we = 0; ex_waddr = 0; ex_wdata = 0;
        lsu_issue = 0; lsu_rd = 0;
        lsu_resp_valid = 0; lsu_resp_err = 0; lsu_rdata = 0;
        id_valid = 0; id_raddr_a = 0; id_ra_used = 0;
        id_raddr_b = 0; id_rb_used = 0; id_waddr = 0; id_we = 0;
    endtask

    // One clock cycle: check outputs against the model, advance the model,
    // then step past the rising edge. Entered and left at posedge + 1.
    task automatic tick(input string tag);
        bit            ld_done, ld_wr, ex_ok, direct, accept;
        logic          e_we, e_st;
        logic [4:0]    e_a;
        logic [DW-1:0] e_d;
        ent_t          e;
        #2;
        ld_done = lsu_resp_valid && m_busy;
        ld_wr   = ld_done && !lsu_resp_err && (m_rd != 5'd0);
        ex_ok   = ex_we && (ex_waddr != 5'd0);
        direct  = ex_ok && !ld_wr && (m_q.size() == 0);
        accept  = lsu_issue && (!m_busy || ld_done);
        e_we = 0; e_a = 0; e_d = 0;
        if (ld_wr) begin
            e_we = 1; e_a = m_rd; e_d = lsu_rdata;
        end else if (m_q.size() > 0) begin
            e_we = 1; e_a = m_q[0].a; e_d = m_q[0].d;
        end else if (direct) begin
            e_we = 1; e_a = ex_waddr; e_d = ex_wdata;
        end
        e_st = (id_valid && ((id_ra_used && hit(id_raddr_a)) ||
                             (id_rb_used && hit(id_raddr_b)) ||
                             (id_we && id_waddr != 5'd0 && m_busy && m_rd == id_waddr)))
               || (m_q.size() >= DEPTH - 1);
        check({tag, ".we"},    64'(we_a),      64'(e_we));
        check({tag, ".waddr"}, 64'(waddr_a),   64'(e_a));
        check({tag, ".wdata"}, 64'(wdata_a),   64'(e_d));
        check({tag, ".stall"}, 64'(reg_stall), 64'(e_st));
        check({tag, ".busy"},  64'(lsu_busy),  64'(m_busy));
        s_we = we_a; s_addr = waddr_a; s_data = wdata_a; s_stall = reg_stall; s_busy = lsu_busy;
        if (!ld_wr && m_q.size() > 0) m_q.delete(0);
        if (ex_ok && !direct) begin
            e.a = ex_waddr; e.d = ex_wdata;
            m_q.push_back(e);
        end
        if (ld_done) m_busy = 0;
        if (accept) begin
            m_busy = 1; m_rd = lsu_rd;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_busy = 0; m_rd = 0;
        m_q.delete();
    endtask

    initial begin
        // Reset with outputs checked while held.
        idle_inputs();
        model_reset();
        rst_n = 0;
        #12;
        check("rst.we", 64'(we_a), 64'd0);
        check("rst.stall", 64'(reg_stall), 64'd0);
        check("rst.busy", 64'(lsu_busy), 64'd0);
        @(negedge clk) rst_n = 1;
        @(posedge clk);
        #1;

        // Direct EX write with nothing else going on.
        ex_we = 1; ex_waddr = 5; ex_wdata = 32'hA5A5_0001;
        tick("ex_direct");
        check("ex_direct.data", 64'(s_data), 64'hA5A5_0001);
        idle_inputs();
        tick("ex_direct_after");
        check("ex_direct.no_buf", 64'(s_we), 64'd0);

        // Load to x7 with a dependent read stalling until the response.
        lsu_issue = 1; lsu_rd = 7;
        tick("ld7_issue");
        idle_inputs();
        id_valid = 1; id_raddr_a = 7; id_ra_used = 1;
        for (int i = 0; i < 3; i++) begin
            tick("ld7_wait");
            check("ld7_wait.stall", 64'(s_stall), 64'd1);
        end
        lsu_resp_valid = 1; lsu_rdata = 32'h1234;
        tick("ld7_resp");
        check("ld7_resp.addr", 64'(s_addr), 64'd7);
        lsu_resp_valid = 0;
        tick("ld7_after");
        check("ld7_after.stall", 64'(s_stall), 64'd0);
        idle_inputs();

        // Load response and EX write in the same cycle.
        lsu_issue = 1; lsu_rd = 3;
        tick("ld3_issue");
        idle_inputs();
        lsu_resp_valid = 1; lsu_rdata = 32'h3333;
        ex_we = 1; ex_waddr = 4; ex_wdata = 32'h44;
        tick("collide");
        check("collide.addr", 64'(s_addr), 64'd3);
        idle_inputs();
        id_valid = 1; id_raddr_b = 4; id_rb_used = 1;
        tick("x4_drain");
        check("x4_drain.addr", 64'(s_addr), 64'd4);
        check("x4_drain.stall", 64'(s_stall), 64'd1);
        idle_inputs();
        tick("x4_idle");

        // Error response: no write, record retired.
        lsu_issue = 1; lsu_rd = 9;
        tick("ld9_issue");
        idle_inputs();
        lsu_resp_valid = 1; lsu_resp_err = 1; lsu_rdata = 32'hDEAD;
        tick("ld9_err");
        check("ld9_err.we", 64'(s_we), 64'd0);
        idle_inputs();
        id_valid = 1; id_we = 1; id_waddr = 9;
        tick("ld9_after");
        check("ld9_after.busy", 64'(s_busy), 64'd0);
        check("ld9_after.stall", 64'(s_stall), 64'd0);
        idle_inputs();

        // Back-to-back EX writes colliding with chained load responses.
        lsu_issue = 1; lsu_rd = 10;
        tick("bp_issue");
        lsu_issue = 1; lsu_rd = 11; lsu_resp_valid = 1; lsu_rdata = 32'h10;
        ex_we = 1; ex_waddr = 20; ex_wdata = 32'hA;
        tick("bp_a");
        lsu_issue = 1; lsu_rd = 13; lsu_resp_valid = 1; lsu_rdata = 32'h11;
        ex_we = 1; ex_waddr = 21; ex_wdata = 32'hB;
        tick("bp_b");
        check("bp_b.stall", 64'(s_stall), 64'd1);
        check("bp_b.addr", 64'(s_addr), 64'd11);
        idle_inputs();
        ex_we = 1; ex_waddr = 22; ex_wdata = 32'hC;
        tick("bp_c");
        check("bp_c.addr", 64'(s_addr), 64'd20);
        idle_inputs();
        tick("bp_d");
        check("bp_d.addr", 64'(s_addr), 64'd21);
        tick("bp_e");
        check("bp_e.addr", 64'(s_addr), 64'd22);
        check("bp_e.data", 64'(s_data), 64'hC);
        lsu_resp_valid = 1; lsu_rdata = 32'h13;
        tick("bp_f");
        check("bp_f.addr", 64'(s_addr), 64'd13);
        idle_inputs();

        // Reset in the middle of an outstanding load.
        lsu_issue = 1; lsu_rd = 12;
        tick("ld12_issue");
        idle_inputs();
        ex_we = 1; ex_waddr = 12; ex_wdata = 32'h77;
        id_valid = 1; id_raddr_a = 12; id_ra_used = 1;
        #2;
        rst_n = 0;
        #1;
        check("midrst.we", 64'(we_a), 64'd0);
        check("midrst.waddr", 64'(waddr_a), 64'd0);
        check("midrst.wdata", 64'(wdata_a), 64'd0);
        check("midrst.stall", 64'(reg_stall), 64'd0);
        check("midrst.busy", 64'(lsu_busy), 64'd0);
        model_reset();
        idle_inputs();
        @(negedge clk) rst_n = 1;
        @(posedge clk);
        #1;
        lsu_resp_valid = 1; lsu_rdata = 32'h999;
        id_valid = 1; id_raddr_a = 12; id_ra_used = 1;
        tick("late_resp");
        check("late_resp.we", 64'(s_we), 64'd0);
        idle_inputs();

        // Random traffic; EX writes are held off once the buffer would fill.
        for (int c = 0; c < 3000; c++) begin
            ex_we          = (m_q.size() < DEPTH - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            ex_waddr       = 5'($urandom_range(0, 7));
            ex_wdata       = $urandom;
            lsu_issue      = ($urandom_range(0, 9) < 3);
            lsu_rd         = 5'($urandom_range(0, 7));
            lsu_resp_valid = ($urandom_range(0, 9) < 4);
            lsu_resp_err   = ($urandom_range(0, 9) < 2);
            lsu_rdata      = $urandom;
            id_valid       = 1'($urandom_range(0, 1));
            id_raddr_a     = 5'($urandom_range(0, 7));
            id_ra_used     = 1'($urandom_range(0, 1));
            id_raddr_b     = 5'($urandom_range(0, 7));
            id_rb_used     = 1'($urandom_range(0, 1));
            id_waddr       = 5'($urandom_range(0, 7));
            id_we          = 1'($urandom_range(0, 1));
            tick("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
